// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
//   Pong game-flow controller. It steps through menu_start -> play ->
//   game_over, counts the serve and game-over hold delays in video frames,
//   keeps both scores and gates the ball datapath. The draw modules read
//   game_state. The ball and collision logic read ball_en and ball_rst.
//
//   State encodings (vga_pkg): menu_start = 2'b00, play = 2'b01,
//   game_over = 2'b10.
//
// Ports
//   clk          in   1        pixel clock
//   rst_n        in   1        asynchronous, active-low reset
//   frame_tick   in   1        1-cycle pulse once per video frame
//   start        in   1        debounced start button, level
//   miss_left    in   1        1-cycle pulse: ball passed the left edge
//   miss_right   in   1        1-cycle pulse: ball passed the right edge
//   game_state   out  2        current game state
//   ball_en      out  1        1 = ball may move
//   ball_rst     out  1        1-cycle pulse: recentre the ball
//   score_left   out  SCORE_W  left player score
//   score_right  out  SCORE_W  right player score
//   winner       out  1        0 = left won, 1 = right won (valid in game_over)
// ---------------------------------------------------------------------------
module game_ctrl #(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 120,
    parameter int SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic [1:0]         game_state,
    output logic               ball_en,
    output logic               ball_rst,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               winner
);

    localparam int CNT_MAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   OVER_LOAD  = CNT_W'(OVER_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    typedef enum logic [1:0] {
        ST_MENU = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ball_en_q, ball_en_d;
    logic               ball_rst_q, ball_rst_d;
    logic [SCORE_W-1:0] score_left_q, score_left_d;
    logic [SCORE_W-1:0] score_right_q, score_right_d;
    logic               winner_q, winner_d;
    logic               start_q;

    logic               start_rise;
    logic               any_miss;
    logic [SCORE_W-1:0] pt_left;    // left score if this cycle's miss is awarded
    logic [SCORE_W-1:0] pt_right;   // right score if this cycle's miss is awarded

    // Holding start must not retrigger, so only the rising edge acts.
    assign start_rise = start & ~start_q;
    assign any_miss   = miss_left | miss_right;

    always_comb begin
        // NOTE: every signal written here gets a default first. A path that
        // leaves one unassigned would infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        ball_en_d     = ball_en_q;
        ball_rst_d    = 1'b0;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        winner_d      = winner_q;

        // A miss scores for the opposite player. A simultaneous double
        // miss is a draw point. Scores saturate at WIN_SCORE.
        pt_left  = score_left_q;
        pt_right = score_right_q;
        if (miss_right && !miss_left && (score_left_q != WIN_VAL)) begin
            pt_left = score_left_q + SCORE_ONE;
        end
        if (miss_left && !miss_right && (score_right_q != WIN_VAL)) begin
            pt_right = score_right_q + SCORE_ONE;
        end

        case (state_q)
            ST_MENU: begin
                score_left_d  = '0;
                score_right_d = '0;
                ball_en_d     = 1'b0;
                if (start_rise) begin
                    state_d    = ST_PLAY;
                    ball_rst_d = 1'b1;
                    cnt_d      = SERVE_LOAD;
                    winner_d   = 1'b0;
                end
            end

            ST_PLAY: begin
                if (cnt_q != '0) begin
                    // Serving: the ball is held and misses are ignored.
                    ball_en_d = 1'b0;
                    if (frame_tick) begin
                        cnt_d = cnt_q - CNT_ONE;
                        // Release the ball as the counter reaches zero, so
                        // ball_en rises one cycle after the final tick.
                        if (cnt_q == CNT_ONE) begin
                            ball_en_d = 1'b1;
                        end
                    end
                end else if (any_miss) begin
                    score_left_d  = pt_left;
                    score_right_d = pt_right;
                    ball_en_d     = 1'b0;
                    ball_rst_d    = 1'b1;
                    if ((pt_left == WIN_VAL) || (pt_right == WIN_VAL)) begin
                        state_d  = ST_OVER;
                        winner_d = (pt_right == WIN_VAL);
                        cnt_d    = OVER_LOAD;
                    end else begin
                        cnt_d = SERVE_LOAD;
                    end
                end else begin
                    ball_en_d = 1'b1;
                end
            end

            ST_OVER: begin
                // Scores stay frozen. start is ignored until the hold expires.
                ball_en_d = 1'b0;
                if (cnt_q != '0) begin
                    if (frame_tick) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else if (start_rise) begin
                    state_d       = ST_MENU;
                    score_left_d  = '0;
                    score_right_d = '0;
                end
            end

            default: begin
                // An unreachable encoding recovers to the menu.
                state_d       = ST_MENU;
                cnt_d         = '0;
                ball_en_d     = 1'b0;
                score_left_d  = '0;
                score_right_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_MENU;
            cnt_q         <= '0;
            ball_en_q     <= 1'b0;
            ball_rst_q    <= 1'b0;
            score_left_q  <= '0;
            score_right_q <= '0;
            winner_q      <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples the values from before this edge.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ball_en_q     <= ball_en_d;
            ball_rst_q    <= ball_rst_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            winner_q      <= winner_d;
            start_q       <= start;
        end
    end

    assign game_state  = state_q;
    assign ball_en     = ball_en_q;
    assign ball_rst    = ball_rst_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl
//   Directed bench for game_ctrl with SERVE_FRAMES=3, OVER_FRAMES=2,
//   WIN_SCORE=3, SCORE_W=4. A vector table walks through one full game and
//   the start of a second. Hand-written sequences cover the held start
//   button and an asynchronous reset in the middle of a rally.
// ---------------------------------------------------------------------------
module tb_game_ctrl;

    localparam int SCORE_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               frame_tick;
    logic               start;
    logic               miss_left;
    logic               miss_right;
    logic [1:0]         game_state;
    logic               ball_en;
    logic               ball_rst;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic               winner;

    int tests  = 0;
    int failed = 0;

    game_ctrl #(
        .WIN_SCORE   (3),
        .SERVE_FRAMES(3),
        .OVER_FRAMES (2),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .start      (start),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .game_state (game_state),
        .ball_en    (ball_en),
        .ball_rst   (ball_rst),
        .score_left (score_left),
        .score_right(score_right),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       ft;
        logic       ml;
        logic       mr;
        logic [1:0] state;
        logic       en;
        logic       rst;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       win;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic st, input logic ft, input logic ml, input logic mr);
        start      = st;
        frame_tick = ft;
        miss_left  = ml;
        miss_right = mr;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic st, ft, ml, mr, input logic [1:0] s,
                                input logic en, rs, input int sl, sr, input logic w);
        vec_t v;
        v.st = st; v.ft = ft; v.ml = ml; v.mr = mr;
        v.state = s; v.en = en; v.rst = rs;
        v.sl = 4'(sl); v.sr = 4'(sr); v.win = w;
        vecs.push_back(v);
    endfunction

    // Packed view of the outputs: {state, ball_en, ball_rst, score_left, score_right}.
    function automatic logic [31:0] pack(input logic [1:0] s, input logic en, rs,
                                         input logic [3:0] sl, sr);
        return {20'd0, s, en, rs, sl, sr};
    endfunction

    initial begin
        int rst_pulses;

        //      st ft ml mr  state en rst sl sr win
        // Serve countdown, with a miss during serving (cnt=2) ignored.
        add(0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0);  // 0: cnt 3->2
        add(0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0);  // 1: miss while serving
        add(0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0);  // 2: cnt 2->1
        add(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0);  // 3: no tick, still held
        add(0, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0);  // 4: 3rd tick -> ball_en
        // Right scores on a left miss.
        add(0, 0, 1, 0, 2'b01, 0, 1, 0, 1, 0);  // 5
        add(0, 1, 0, 0, 2'b01, 0, 0, 0, 1, 0);  // 6
        add(0, 1, 0, 0, 2'b01, 0, 0, 0, 1, 0);  // 7
        add(0, 1, 0, 0, 2'b01, 1, 0, 0, 1, 0);  // 8
        // Double miss: draw point, re-serve for three frames.
        add(0, 0, 1, 1, 2'b01, 0, 1, 0, 1, 0);  // 9
        add(0, 1, 0, 0, 2'b01, 0, 0, 0, 1, 0);  // 10
        add(0, 1, 0, 0, 2'b01, 0, 0, 0, 1, 0);  // 11
        add(0, 1, 0, 0, 2'b01, 1, 0, 0, 1, 0);  // 12
        add(0, 0, 1, 0, 2'b01, 0, 1, 0, 2, 0);  // 13: right 2
        add(0, 1, 0, 0, 2'b01, 0, 0, 0, 2, 0);  // 14
        add(0, 1, 0, 0, 2'b01, 0, 0, 0, 2, 0);  // 15
        add(0, 1, 0, 0, 2'b01, 1, 0, 0, 2, 0);  // 16
        add(0, 0, 0, 1, 2'b01, 0, 1, 1, 2, 0);  // 17: left scores
        add(0, 1, 0, 0, 2'b01, 0, 0, 1, 2, 0);  // 18
        add(0, 1, 0, 0, 2'b01, 0, 0, 1, 2, 0);  // 19
        add(0, 1, 0, 0, 2'b01, 1, 0, 1, 2, 0);  // 20
        add(0, 0, 1, 0, 2'b10, 0, 1, 1, 3, 1);  // 21: right wins
        // game_over hold of two frames.
        add(0, 0, 0, 0, 2'b10, 0, 0, 1, 3, 1);  // 22
        add(0, 0, 1, 0, 2'b10, 0, 0, 1, 3, 1);  // 23: scores frozen
        add(0, 1, 0, 0, 2'b10, 0, 0, 1, 3, 1);  // 24: cnt 2->1
        add(1, 0, 0, 0, 2'b10, 0, 0, 1, 3, 1);  // 25: early start ignored
        add(0, 0, 0, 0, 2'b10, 0, 0, 1, 3, 1);  // 26
        add(0, 1, 0, 0, 2'b10, 0, 0, 1, 3, 1);  // 27: cnt 1->0
        add(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);  // 28: back to menu
        add(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);  // 29: held start, no retrigger
        add(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);  // 30
        add(1, 0, 0, 0, 2'b01, 0, 1, 0, 0, 0);  // 31: new game, scores 0
        add(0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0);  // 32
        add(0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0);  // 33
        add(0, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0);  // 34
        add(0, 0, 0, 1, 2'b01, 0, 1, 1, 0, 0);  // 35
        add(0, 1, 0, 0, 2'b01, 0, 0, 1, 0, 0);  // 36
        add(0, 1, 0, 0, 2'b01, 0, 0, 1, 0, 0);  // 37
        add(0, 1, 0, 0, 2'b01, 1, 0, 1, 0, 0);  // 38
        add(0, 0, 0, 1, 2'b01, 0, 1, 2, 0, 0);  // 39
        add(0, 1, 0, 0, 2'b01, 0, 0, 2, 0, 0);  // 40
        add(0, 1, 0, 0, 2'b01, 0, 0, 2, 0, 0);  // 41
        add(0, 1, 0, 0, 2'b01, 1, 0, 2, 0, 0);  // 42: rally, left=2

        // Reset state.
        rst_n      = 1'b0;
        start      = 1'b0;
        frame_tick = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", pack(game_state, ball_en, ball_rst, score_left, score_right),
              pack(2'b00, 1'b0, 1'b0, 4'd0, 4'd0));
        check("reset_winner", {31'd0, winner}, 32'd0);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        check("menu_idle", pack(game_state, ball_en, ball_rst, score_left, score_right),
              pack(2'b00, 1'b0, 1'b0, 4'd0, 4'd0));

        // start held for 50 cycles: exactly one ball_rst pulse.
        rst_pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step(1, 0, 0, 0);
            if (ball_rst) rst_pulses++;
        end
        check("held_start_pulses", 32'(rst_pulses), 32'd1);
        check("held_start_state", pack(game_state, ball_en, ball_rst, score_left, score_right),
              pack(2'b01, 1'b0, 1'b0, 4'd0, 4'd0));

        // Table-driven game.
        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].ft, vecs[i].ml, vecs[i].mr);
            check($sformatf("vec%0d", i),
                  pack(game_state, ball_en, ball_rst, score_left, score_right),
                  pack(vecs[i].state, vecs[i].en, vecs[i].rst, vecs[i].sl, vecs[i].sr));
            if (vecs[i].state == 2'b10) begin
                check($sformatf("vec%0d_winner", i), {31'd0, winner}, {31'd0, vecs[i].win});
            end
        end

        // Asynchronous reset mid-rally: outputs clear without a clock edge.
        rst_n = 1'b0;
        #1;
        check("async_reset", pack(game_state, ball_en, ball_rst, score_left, score_right),
              pack(2'b00, 1'b0, 1'b0, 4'd0, 4'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, 1, 0);
        check("after_reset", pack(game_state, ball_en, ball_rst, score_left, score_right),
              pack(2'b00, 1'b0, 1'b0, 4'd0, 4'd0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
